// File: rtl/nic_channel_interface.sv
// nic_channel_interface: processor-visible NIC with single-entry ejection and
// injection buffers, ready/valid router handshake and VC polarity send gating.
module nic_channel_interface #(
  parameter int DATA_WIDTH = 64,
  parameter int VC_BIT     = 63
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            addr,
  input  logic                  nicEn,
  input  logic                  nicEnWr,
  input  logic [DATA_WIDTH-1:0] d_in,
  output logic [DATA_WIDTH-1:0] d_out,
  input  logic                  net_si,
  output logic                  net_ri,
  input  logic [DATA_WIDTH-1:0] net_di,
  output logic                  net_so,
  input  logic                  net_ro,
  output logic [DATA_WIDTH-1:0] net_do,
  input  logic                  net_polarity
);

  localparam logic [1:0] A_IBUF = 2'b00;
  localparam logic [1:0] A_ISTS = 2'b01;
  localparam logic [1:0] A_OBUF = 2'b10;
  localparam logic [1:0] A_OSTS = 2'b11;

  logic [DATA_WIDTH-1:0] r_in_buf, r_out_buf, r_d_out, r_net_do;
  logic                  r_in_full, r_out_full, r_net_so;

  logic w_rd, w_wr, w_accept, w_rd_ibuf, w_load_obuf, w_send;

  assign w_rd        = nicEn & ~nicEnWr;
  assign w_wr        = nicEn &  nicEnWr;
  assign w_accept    = net_si & ~r_in_full;
  assign w_rd_ibuf   = w_rd & (addr == A_IBUF);
  // A store that lands on the same edge as a send sees out_full=1 and is dropped.
  assign w_load_obuf = w_wr & (addr == A_OBUF) & ~r_out_full;
  assign w_send      = r_out_full & net_ro & (net_polarity == r_out_buf[VC_BIT]);

  assign net_ri = ~r_in_full;
  assign d_out  = r_d_out;
  assign net_so = r_net_so;
  assign net_do = r_net_do;

  // Ejection buffer: capture from the router when empty, drain on a buffer read.
  // An accept can only happen while empty, so it takes precedence over a read
  // of the (already empty) buffer and the incoming packet is never lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_in_buf  <= '0;
      r_in_full <= 1'b0;
    end else if (w_accept) begin
      r_in_buf  <= net_di;
      r_in_full <= 1'b1;
    end else if (w_rd_ibuf) begin
      r_in_full <= 1'b0;
    end
  end

  // Injection buffer: filled by a processor store, emptied by a send.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_buf  <= '0;
      r_out_full <= 1'b0;
    end else if (w_load_obuf) begin
      r_out_buf  <= d_in;
      r_out_full <= 1'b1;
    end else if (w_send) begin
      r_out_full <= 1'b0;
    end
  end

  // Registered load data; holds its value when no read is issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_d_out <= '0;
    end else if (w_rd) begin
      unique case (addr)
        A_IBUF:  r_d_out <= r_in_buf;
        A_ISTS:  r_d_out <= {{(DATA_WIDTH-1){1'b0}}, r_in_full};
        A_OBUF:  r_d_out <= '0;
        A_OSTS:  r_d_out <= {{(DATA_WIDTH-1){1'b0}}, r_out_full};
        default: r_d_out <= '0;
      endcase
    end
  end

  // Router-side output: one-cycle valid pulse per packet, data held between sends.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_net_so <= 1'b0;
      r_net_do <= '0;
    end else begin
      r_net_so <= w_send;
      if (w_send) r_net_do <= r_out_buf;
    end
  end

endmodule
